// File: rtl/me_feeder.sv
// Streaming front end for the full-search SAD array: reads the template block and
// search window from pixel memories and tags each SAD result with its candidate offset.
module me_feeder #(
    parameter int TB_LENGTH   = 16,
    parameter int SW_LENGTH   = 48,
    parameter int SAD_LATENCY = 2,
    parameter int TB_AW       = 8,
    parameter int SW_AW       = 12,
    parameter int MV_WIDTH    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                tb_rd,
    output logic [TB_AW-1:0]    tb_addr,
    input  logic [7:0]          tb_rdata,
    output logic                sw_rd,
    output logic [SW_AW-1:0]    sw_addr,
    input  logic [7:0]          sw_rdata,
    output logic                en_tb,
    output logic [7:0]          pel_tb,
    output logic                en_sw,
    output logic [7:0]          pel_sw,
    output logic                cand_valid,
    output logic [MV_WIDTH-1:0] cand_x,
    output logic [MV_WIDTH-1:0] cand_y
);

    localparam int CW = $clog2(SW_LENGTH);
    localparam int DW = $clog2(SAD_LATENCY + 2);

    localparam logic [TB_AW-1:0] TB_LAST    = TB_AW'(TB_LENGTH * TB_LENGTH - 1);
    localparam logic [SW_AW-1:0] SW_LAST    = SW_AW'(SW_LENGTH * SW_LENGTH - 1);
    localparam logic [CW-1:0]    EDGE       = CW'(TB_LENGTH - 1);
    localparam logic [CW-1:0]    POS_LAST   = CW'(SW_LENGTH - 1);
    localparam logic [DW-1:0]    DONE_AT    = DW'(SAD_LATENCY);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(SAD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_TB,
        LOAD_SW,
        DRAIN
    } state_t;

    state_t               state;
    logic [DW-1:0]        drain_cnt;
    logic [CW-1:0]        col;
    logic [CW-1:0]        row;
    logic                 tag_valid;
    logic [MV_WIDTH-1:0]  tag_x;
    logic [MV_WIDTH-1:0]  tag_y;
    logic                 pipe_v [SAD_LATENCY];
    logic [MV_WIDTH-1:0]  pipe_x [SAD_LATENCY];
    logic [MV_WIDTH-1:0]  pipe_y [SAD_LATENCY];

    assign pel_tb = tb_rdata;
    assign pel_sw = sw_rdata;

    // Done is raised one cycle before leaving DRAIN so busy is still high in the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            tb_rd     <= 1'b0;
            sw_rd     <= 1'b0;
            tb_addr   <= '0;
            sw_addr   <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD_TB;
                        busy    <= 1'b1;
                        tb_rd   <= 1'b1;
                        tb_addr <= '0;
                        sw_addr <= '0;
                    end
                end
                LOAD_TB: begin
                    if (tb_addr == TB_LAST) begin
                        state   <= LOAD_SW;
                        tb_rd   <= 1'b0;
                        sw_rd   <= 1'b1;
                        sw_addr <= '0;
                    end else begin
                        tb_addr <= tb_addr + 1'b1;
                    end
                end
                LOAD_SW: begin
                    if (sw_addr == SW_LAST) begin
                        state     <= DRAIN;
                        sw_rd     <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        sw_addr <= sw_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                        if (drain_cnt == DONE_AT) begin
                            done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_tb <= 1'b0;
            en_sw <= 1'b0;
        end else begin
            en_tb <= tb_rd;
            en_sw <= sw_rd;
        end
    end

    // col/row name the search-window pixel currently on pel_sw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (en_sw) begin
            if (col == POS_LAST) begin
                col <= '0;
                row <= (row == POS_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_comb begin
        tag_valid = en_sw && (col >= EDGE) && (row >= EDGE);
        tag_x     = '0;
        tag_y     = '0;
        if (tag_valid) begin
            tag_x = MV_WIDTH'(col - EDGE);
            tag_y = MV_WIDTH'(row - EDGE);
        end
    end

    // Delay line matching the array's adder pipeline so tags line up with sad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SAD_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_x[i] <= '0;
                pipe_y[i] <= '0;
            end
        end else begin
            pipe_v[0] <= tag_valid;
            pipe_x[0] <= tag_x;
            pipe_y[0] <= tag_y;
            for (int i = 1; i < SAD_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_x[i] <= pipe_x[i-1];
                pipe_y[i] <= pipe_y[i-1];
            end
        end
    end

    assign cand_valid = pipe_v[SAD_LATENCY-1];
    assign cand_x     = pipe_x[SAD_LATENCY-1];
    assign cand_y     = pipe_y[SAD_LATENCY-1];

endmodule

// File: tb/tb_me_feeder.sv
// Scoreboard bench for me_feeder: expected candidate tags are queued at start and
// matched by a monitor; a software SAD model checks the golden block is found.
module tb_me_feeder;

    localparam int SAD_LAT = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       tb_rd;
    logic [7:0] tb_addr;
    logic [7:0] tb_rdata;
    logic       sw_rd;
    logic [11:0] sw_addr;
    logic [7:0] sw_rdata;
    logic       en_tb;
    logic [7:0] pel_tb;
    logic       en_sw;
    logic [7:0] pel_sw;
    logic       cand_valid;
    logic [5:0] cand_x;
    logic [5:0] cand_y;

    me_feeder #(
        .TB_LENGTH(16), .SW_LENGTH(48), .SAD_LATENCY(SAD_LAT),
        .TB_AW(8), .SW_AW(12), .MV_WIDTH(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .tb_rd(tb_rd), .tb_addr(tb_addr), .tb_rdata(tb_rdata),
        .sw_rd(sw_rd), .sw_addr(sw_addr), .sw_rdata(sw_rdata),
        .en_tb(en_tb), .pel_tb(pel_tb), .en_sw(en_sw), .pel_sw(pel_sw),
        .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y)
    );

    typedef struct {
        int x;
        int y;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       exp_item;
    logic [7:0] tb_mem [256];
    logic [7:0] sw_mem [2304];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         en_tb_cnt, en_sw_cnt, cand_cnt, done_cnt;
    int         exp_tb_addr, exp_sw_addr, exp_tb_pix, exp_sw_pix;
    int         min_sad, min_x, min_y, sad, diff;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (tb_rd) tb_rdata <= tb_mem[int'(tb_addr)];
        if (sw_rd) sw_rdata <= sw_mem[int'(sw_addr) % 2304];
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_tb_rd"}, tb_rd, 0);
        checkOutput({tag, "_sw_rd"}, sw_rd, 0);
        checkOutput({tag, "_en_tb"}, en_tb, 0);
        checkOutput({tag, "_en_sw"}, en_sw, 0);
        checkOutput({tag, "_cand_valid"}, cand_valid, 0);
        checkOutput({tag, "_tb_addr"}, tb_addr, 0);
        checkOutput({tag, "_sw_addr"}, sw_addr, 0);
        checkOutput({tag, "_cand_x"}, cand_x, 0);
        checkOutput({tag, "_cand_y"}, cand_y, 0);
    endtask

    task automatic clearTracking();
        en_tb_cnt   = 0;
        en_sw_cnt   = 0;
        cand_cnt    = 0;
        done_cnt    = 0;
        exp_tb_addr = 0;
        exp_sw_addr = 0;
        exp_tb_pix  = 0;
        exp_sw_pix  = 0;
        min_sad     = 1 << 30;
        min_x       = -1;
        min_y       = -1;
    endtask

    // Monitor: address/pixel streams, pulse counts, and scoreboard pops on cand_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tb_rd) begin
                checkOutput("tb_addr_seq", tb_addr, exp_tb_addr);
                checkOutput("rd_exclusive", sw_rd, 0);
                exp_tb_addr++;
            end
            if (sw_rd) begin
                checkOutput("sw_addr_seq", sw_addr, exp_sw_addr);
                exp_sw_addr++;
            end
            if (en_tb) begin
                en_tb_cnt++;
                checkOutput("pel_tb", pel_tb, tb_mem[exp_tb_pix % 256]);
                exp_tb_pix++;
            end
            if (en_sw) begin
                en_sw_cnt++;
                checkOutput("pel_sw", pel_sw, sw_mem[exp_sw_pix % 2304]);
                exp_sw_pix++;
            end
            if (done) done_cnt++;
            if (cand_valid) begin
                cand_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL cand_extra: actual=(%0d,%0d) required=none (cycle %0d)", cand_x, cand_y, cyc);
                end else begin
                    exp_item = exp_q.pop_front();
                    checkOutput("cand_x", cand_x, exp_item.x);
                    checkOutput("cand_y", cand_y, exp_item.y);
                    checkOutput("cand_cycle", cyc, exp_item.cyc);
                end
                if (cand_x <= 6'd32 && cand_y <= 6'd32) begin
                    sad = 0;
                    for (int r = 0; r < 16; r++) begin
                        for (int c = 0; c < 16; c++) begin
                            diff = int'(tb_mem[r*16 + c]) - int'(sw_mem[(int'(cand_y) + r)*48 + int'(cand_x) + c]);
                            sad += (diff < 0) ? -diff : diff;
                        end
                    end
                    if (sad < min_sad) begin
                        min_sad = sad;
                        min_x   = cand_x;
                        min_y   = cand_y;
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                exp_item = exp_q.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL cand_missing: actual=none required=(%0d,%0d) at cycle %0d", exp_item.x, exp_item.y, exp_item.cyc);
            end
        end
    end

    // One full search started at the current negedge; poke also pulses start while busy and in the done cycle.
    task automatic applyStimulus(input bit poke);
        int k;
        clearTracking();
        k = cyc;
        // Start sampled at edge k+1; en_tb spans k+2..k+257, pixel p has en_sw at k+258+p.
        for (int y = 0; y <= 32; y++) begin
            for (int x = 0; x <= 32; x++) begin
                exp_q.push_back('{x, y, k + 258 + SAD_LAT + (y + 15)*48 + x + 15});
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            start = poke && (i == 100);
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("done_seen", done, 1);
        checkOutput("done_cycle", cyc, k + 2562 + SAD_LAT);
        checkOutput("busy_in_done", busy, 1);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_done", busy, 0);
        checkOutput("done_one_cycle", done, 0);
        if (poke) begin
            repeat (3) @(negedge clk);
            checkOutput("no_restart_busy", busy, 0);
            checkOutput("no_restart_tb_rd", tb_rd, 0);
        end
        checkOutput("en_tb_count", en_tb_cnt, 256);
        checkOutput("en_sw_count", en_sw_cnt, 2304);
        checkOutput("cand_count", cand_cnt, 1089);
        checkOutput("done_count", done_cnt, 1);
        checkOutput("queue_left", exp_q.size(), 0);
        checkOutput("min_sad", min_sad, 0);
        checkOutput("min_sad_x", min_x, 7);
        checkOutput("min_sad_y", min_y, 11);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clearTracking();
        for (int i = 0; i < 2304; i++) sw_mem[i] = 8'($urandom);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                tb_mem[r*16 + c] = sw_mem[(r + 11)*48 + c + 7];
            end
        end

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_tb_rd", tb_rd, 0);

        // Abort a search partway through LOAD_SW with an asynchronous reset.
        clearTracking();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (399) @(negedge clk);
        checkOutput("pre_reset_sw_rd", sw_rd, 1);
        checkOutput("pre_reset_en_sw", en_sw, 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_sw_rd", sw_rd, 0);
        checkOutput("post_reset_tb_rd", tb_rd, 0);

        $display("[TB] search 1");
        applyStimulus(1'b0);
        $display("[TB] search 2 (start one cycle after done, pokes while busy and in done)");
        applyStimulus(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
